branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which is the operand and PC width in bits (minimum 8).
REQ-002 SHALL have parameter BHT_IDX, default 6, giving a branch history table of 2^BHT_IDX two-bit counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an instruction is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an instruction this cycle.
REQ-007 SHALL have port op, input, 6 bits, and port rt, input, 5 bits: MIPS opcode and rt fields.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: rs and rt operand values.
REQ-009 SHALL have port pc, input, WIDTH bits: the branch instruction address.
REQ-010 SHALL have port imm, input, 16 bits: the branch offset field.
REQ-011 SHALL have port pred_taken, input, 1 bit: the prediction the fetch stage used for this instruction.
REQ-012 SHALL have port flush, input, 1 bit: discard held and incoming work.
REQ-013 SHALL have port q_pc, input, WIDTH bits, and port q_taken, output, 1 bit: the fetch-side prediction query.
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-015 SHALL have the result outputs out_is_branch (1 bit), out_taken (1), out_mispredict (1), out_link (1), out_redirect (WIDTH) and out_link_addr (WIDTH).

Function
REQ-016 SHALL decode op as follows: BEQ=000100 taken if a==b; BNE=000101 taken if a!=b; BLEZ=000110 taken if a[WIDTH-1]==1 or a==0; BGTZ=000111 taken if a[WIDTH-1]==0 and a!=0.
REQ-017 SHALL decode op REGIMM=000001 by rt as follows: BLTZ=00000 and BLTZAL=10000 taken if a[WIDTH-1]==1; BGEZ=00001 and BGEZAL=10001 taken if a[WIDTH-1]==0.
REQ-018 SHALL treat any other op/rt combination as a non-branch: is_branch=0, taken=0, link=0.
REQ-019 SHALL compute target = pc + 4 + (sign-extended imm << 2), and fall-through = pc + 8 (delay slot); all arithmetic is modulo 2^WIDTH with wrap-around permitted.
REQ-020 SHALL register all results: out_redirect = taken ? target : fall-through; out_mispredict = taken XOR pred_taken; out_link = 1 only for BLTZAL/BGEZAL; out_link_addr = pc + 8.
REQ-021 SHALL hold results in a single-entry output register, drive in_ready = !out_valid || out_ready, and accept an instruction on in_valid && in_ready && !flush; results appear the next cycle (latency 1).
REQ-022 SHALL hold out_valid and all result outputs stable while out_valid && !out_ready.
REQ-023 SHALL, on flush, clear out_valid next cycle and drop any same-cycle input (no result, no table update); flush overrides a simultaneous accept.
REQ-024 SHALL index the table by pc[BHT_IDX+1:2]; each counter is a saturating state: SNT=00, WNT=01, WT=10, ST=11; taken moves one state up (ST holds), not-taken moves one down (SNT holds).
REQ-025 SHALL update the table only on accepted instructions with is_branch=1, in the acceptance cycle.
REQ-026 SHALL drive q_taken combinationally as counter[1] of entry q_pc[BHT_IDX+1:2]; when the query and update hit the same entry in the same cycle, q_taken returns the pre-update value.

Reset
REQ-027 SHALL, on rst asserted and asynchronously, force out_valid=0, all result registers to 0, and every table counter to WNT (01); in_ready=1 and q_taken=0 after reset.
REQ-028 SHALL, on reset asserted mid-handshake, lose any held result without an out_valid glitch after deassertion.

Configuration
REQ-029 SHALL, with macro BRANCH_RESOLVE_BHT_EN defined, implement the table and update as in REQ-024 to REQ-026.
REQ-030 SHALL, without BRANCH_RESOLVE_BHT_EN, contain no table, tie q_taken to 0 (static not-taken), and leave all other behaviour unchanged.

Verification
REQ-031 SHALL cover: BEQ with a=b=0x1234, pc=0x100, imm=0x0003, pred_taken=0 -> out_taken=1, out_redirect=0x110, out_mispredict=1 one cycle later.
REQ-032 SHALL cover: BGEZAL with a=0x80000000, pc=0x200 -> out_taken=0, out_redirect=0x208, out_link=1, out_link_addr=0x208.
REQ-033 SHALL cover: BNE with imm=0xFFFF and pc=0x0 -> target 0x0 (wraps), verifying the sign extension.
REQ-034 SHALL cover: four taken branches at pc=0x40 with BHT_EN -> q_taken(0x40) = 0,1,1,1 across the updates, the counter saturates at ST, and a query of another index is unaffected.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; flush on the 2nd cycle -> out_valid=0 next cycle and no table change.
REQ-036 SHALL cover: rst pulsed while out_valid=1 -> out_valid=0 immediately and all counters read WNT.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Handshake and payload bundle between the issue side and the branch resolver.
// The fetch-side prediction query (q_pc/q_taken) travels on the same bundle.
interface branch_resolve_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       op;
  logic [4:0]       rt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] pc;
  logic [15:0]      imm;
  logic             pred_taken;
  logic             flush;
  logic [WIDTH-1:0] q_pc;
  logic             q_taken;
  logic             out_valid;
  logic             out_ready;
  logic             out_is_branch;
  logic             out_taken;
  logic             out_mispredict;
  logic             out_link;
  logic [WIDTH-1:0] out_redirect;
  logic [WIDTH-1:0] out_link_addr;

  modport master (
    output in_valid, op, rt, a, b, pc, imm, pred_taken, flush, q_pc, out_ready,
    input  in_ready, q_taken, out_valid, out_is_branch, out_taken,
           out_mispredict, out_link, out_redirect, out_link_addr
  );

  modport slave (
    input  in_valid, op, rt, a, b, pc, imm, pred_taken, flush, q_pc, out_ready,
    output in_ready, q_taken, out_valid, out_is_branch, out_taken,
           out_mispredict, out_link, out_redirect, out_link_addr
  );
endinterface

// File: rtl/branch_resolve.sv
// MIPS conditional-branch resolver with a single-entry output register.
// Optional 2-bit branch history table enabled by macro BRANCH_RESOLVE_BHT_EN.
module branch_resolve #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BHT_IDX = 6
) (
  input logic           clk,
  input logic           rst,
  branch_resolve_if.slave bus
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef struct packed {
    logic             is_branch;
    logic             taken;
    logic             mispredict;
    logic             link;
    logic [WIDTH-1:0] redirect;
    logic [WIDTH-1:0] link_addr;
  } result_t;

  result_t          res_q;
  logic             valid_q;

  logic             is_branch_c;
  logic             taken_c;
  logic             link_c;
  logic             a_neg_c;
  logic             a_zero_c;
  logic [WIDTH-1:0] imm_sx_c;
  logic [WIDTH-1:0] target_c;
  logic [WIDTH-1:0] fall_c;
  logic             accept_c;
  result_t          res_c;

  // Condition decode; anything unrecognised resolves as a non-branch.
  always_comb begin
    is_branch_c = 1'b0;
    taken_c     = 1'b0;
    link_c      = 1'b0;
    a_neg_c     = bus.a[WIDTH-1];
    a_zero_c    = (bus.a == '0);
    unique case (bus.op)
      OP_BEQ: begin
        is_branch_c = 1'b1;
        taken_c     = (bus.a == bus.b);
      end
      OP_BNE: begin
        is_branch_c = 1'b1;
        taken_c     = (bus.a != bus.b);
      end
      OP_BLEZ: begin
        is_branch_c = 1'b1;
        taken_c     = a_neg_c || a_zero_c;
      end
      OP_BGTZ: begin
        is_branch_c = 1'b1;
        taken_c     = !a_neg_c && !a_zero_c;
      end
      OP_REGIMM: begin
        unique case (bus.rt)
          RT_BLTZ: begin
            is_branch_c = 1'b1;
            taken_c     = a_neg_c;
          end
          RT_BLTZAL: begin
            is_branch_c = 1'b1;
            taken_c     = a_neg_c;
            link_c      = 1'b1;
          end
          RT_BGEZ: begin
            is_branch_c = 1'b1;
            taken_c     = !a_neg_c;
          end
          RT_BGEZAL: begin
            is_branch_c = 1'b1;
            taken_c     = !a_neg_c;
            link_c      = 1'b1;
          end
          default: begin
            is_branch_c = 1'b0;
          end
        endcase
      end
      default: begin
        is_branch_c = 1'b0;
      end
    endcase
  end

  // Address arithmetic wraps modulo 2^WIDTH; pc+8 skips the delay slot.
  assign imm_sx_c = WIDTH'($signed(bus.imm));
  assign target_c = bus.pc + WIDTH'(4) + {imm_sx_c[WIDTH-3:0], 2'b00};
  assign fall_c   = bus.pc + WIDTH'(8);

  always_comb begin
    res_c            = '0;
    res_c.is_branch  = is_branch_c;
    res_c.taken      = taken_c;
    res_c.mispredict = taken_c ^ bus.pred_taken;
    res_c.link       = link_c;
    res_c.redirect   = taken_c ? target_c : fall_c;
    res_c.link_addr  = fall_c;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept_c     = bus.in_valid && bus.in_ready && !bus.flush;

  // Output register: flush wins over accept, results only move on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept_c) begin
      valid_q <= 1'b1;
      res_q   <= res_c;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_is_branch  = res_q.is_branch;
  assign bus.out_taken      = res_q.taken;
  assign bus.out_mispredict = res_q.mispredict;
  assign bus.out_link       = res_q.link;
  assign bus.out_redirect   = res_q.redirect;
  assign bus.out_link_addr  = res_q.link_addr;

`ifdef BRANCH_RESOLVE_BHT_EN
  localparam int unsigned DEPTH = 1 << BHT_IDX;

  logic [1:0]         bht_q [DEPTH];
  logic [BHT_IDX-1:0] upd_idx_c;
  logic [BHT_IDX-1:0] qry_idx_c;
  logic               q_unused_c;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic tk);
    if (tk) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  assign upd_idx_c  = bus.pc[BHT_IDX+1:2];
  assign qry_idx_c  = bus.q_pc[BHT_IDX+1:2];
  assign q_unused_c = ^{bus.q_pc[WIDTH-1:BHT_IDX+2], bus.q_pc[1:0]};

  // Query reads the registered counter, so a same-cycle update is not visible.
  assign bus.q_taken = bht_q[qry_idx_c][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (accept_c && is_branch_c) begin
      bht_q[upd_idx_c] <= sat_next(bht_q[upd_idx_c], taken_c);
    end
  end
`else
  logic q_unused_c;

  // Static not-taken prediction.
  assign q_unused_c  = ^bus.q_pc;
  assign bus.q_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: decode vector table plus handshake,
// flush, reset and history-table sequences.
module tb_branch_resolve;

`ifdef BRANCH_RESOLVE_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  branch_resolve_if #(.WIDTH(32)) bus ();

  branch_resolve #(.WIDTH(32), .BHT_IDX(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        pred;
    logic        br;
    logic        tk;
    logic        mis;
    logic        lnk;
    logic [31:0] red;
    logic [31:0] la;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [15:0] imm,
                       input logic pred);
    bus.in_valid   = 1'b1;
    bus.op         = op;
    bus.rt         = rt;
    bus.a          = a;
    bus.b          = b;
    bus.pc         = pc;
    bus.imm        = imm;
    bus.pred_taken = pred;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.rt = '0; bus.a = '0; bus.b = '0;
    bus.pc = '0; bus.imm = '0; bus.pred_taken = 1'b0; bus.flush = 1'b0;
    bus.q_pc = '0; bus.out_ready = 1'b1;

    //      op     rt     a             b          pc            imm      pr  br  tk  mis lnk redirect      link_addr
    vecs[0]  = '{6'h04, 5'h00, 32'h1234,     32'h1234, 32'h100,      16'h0003, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h110,      32'h108};
    vecs[1]  = '{6'h01, 5'h11, 32'h80000000, 32'h0,    32'h200,      16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h208,      32'h208};
    vecs[2]  = '{6'h05, 5'h00, 32'h1,        32'h2,    32'h0,        16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8};
    vecs[3]  = '{6'h06, 5'h00, 32'h0,        32'h0,    32'h300,      16'h0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h344,      32'h308};
    vecs[4]  = '{6'h07, 5'h00, 32'h0,        32'h0,    32'h300,      16'h0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h308,      32'h308};
    vecs[5]  = '{6'h07, 5'h00, 32'h5,        32'h0,    32'h400,      16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3FC,      32'h408};
    vecs[6]  = '{6'h01, 5'h00, 32'hFFFFFFFF, 32'h0,    32'h500,      16'h0002, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h50C,      32'h508};
    vecs[7]  = '{6'h01, 5'h10, 32'h1,        32'h0,    32'h600,      16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h608,      32'h608};
    vecs[8]  = '{6'h01, 5'h01, 32'h0,        32'h0,    32'h700,      16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFE0704, 32'h708};
    vecs[9]  = '{6'h23, 5'h00, 32'h7,        32'h7,    32'h800,      16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h808,      32'h808};
    vecs[10] = '{6'h01, 5'h02, 32'h80000000, 32'h0,    32'h900,      16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h908,      32'h908};
    vecs[11] = '{6'h04, 5'h00, 32'h1,        32'h2,    32'hFFFFFFF8, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[12] = '{6'h06, 5'h00, 32'h80000000, 32'h0,    32'h0,        16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4,        32'h8};

    // Reset state
    #2;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.q_taken", 64'(bus.q_taken), 64'd0);
    chk("rst.redirect", 64'(bus.out_redirect), 64'd0);
    do_reset();

    // Decode table, one instruction per two cycles with out_ready high
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].op, vecs[i].rt, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm, vecs[i].pred);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d.valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d.is_branch", i), 64'(bus.out_is_branch), 64'(vecs[i].br));
      chk($sformatf("v%0d.taken", i), 64'(bus.out_taken), 64'(vecs[i].tk));
      chk($sformatf("v%0d.mispredict", i), 64'(bus.out_mispredict), 64'(vecs[i].mis));
      chk($sformatf("v%0d.link", i), 64'(bus.out_link), 64'(vecs[i].lnk));
      chk($sformatf("v%0d.redirect", i), 64'(bus.out_redirect), 64'(vecs[i].red));
      chk($sformatf("v%0d.link_addr", i), 64'(bus.out_link_addr), 64'(vecs[i].la));
    end
    @(posedge clk);
    #1;
    chk("drain.out_valid", 64'(bus.out_valid), 64'd0);

    // History table: four back-to-back taken branches at 0x40, then two not-taken
    do_reset();
    bus.q_pc = 32'h40;
    drive(6'h04, 5'h00, 32'h9, 32'h9, 32'h40, 16'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bht.pre%0d", k), 64'(bus.q_taken), 64'((k == 0) ? 1'b0 : BHT));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("bht.st", 64'(bus.q_taken), 64'(BHT));
    drive(6'h05, 5'h00, 32'h9, 32'h9, 32'h40, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    chk("bht.nt1", 64'(bus.q_taken), 64'(BHT));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bht.nt2", 64'(bus.q_taken), 64'd0);
    bus.q_pc = 32'h44;
    #1;
    chk("bht.other", 64'(bus.q_taken), 64'd0);

    // Backpressure with a flush on the second stalled cycle
    do_reset();
    bus.out_ready = 1'b0;
    drive(6'h04, 5'h00, 32'h3, 32'h3, 32'h80, 16'h0002, 1'b0);
    @(posedge clk);
    #1;
    held = bus.out_redirect;
    chk("bp.valid", 64'(bus.out_valid), 64'd1);
    chk("bp.redirect", 64'(held), 64'h8C);
    drive(6'h04, 5'h00, 32'h5, 32'h5, 32'hC0, 16'h0007, 1'b1);
    chk("bp.in_ready0", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("bp.in_ready1", 64'(bus.in_ready), 64'd0);
    chk("bp.stable1", 64'(bus.out_redirect), 64'(held));
    chk("bp.stable_mis", 64'(bus.out_mispredict), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    chk("fl.out_valid", 64'(bus.out_valid), 64'd0);
    bus.q_pc = 32'hC0;
    #1;
    chk("fl.no_update", 64'(bus.q_taken), 64'd0);
    // Flush with the input side open must still drop the instruction
    chk("fl.in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("fl.override", 64'(bus.out_valid), 64'd0);
    chk("fl.q_c0", 64'(bus.q_taken), 64'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.q_pc     = 32'h80;
    #1;
    chk("fl.q_80", 64'(bus.q_taken), 64'(BHT));

    // Asynchronous reset while a result is held
    drive(6'h04, 5'h00, 32'h3, 32'h3, 32'h80, 16'h0002, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("rr.valid_before", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rr.valid_now", 64'(bus.out_valid), 64'd0);
    chk("rr.redirect", 64'(bus.out_redirect), 64'd0);
    chk("rr.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rr.q_wnt", 64'(bus.q_taken), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rr.no_glitch%0d", k), 64'(bus.out_valid), 64'd0);
    end
    // One taken branch from WNT reaches WT, proving the reset value
    bus.out_ready = 1'b1;
    drive(6'h04, 5'h00, 32'h3, 32'h3, 32'h80, 16'h0002, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("rr.wnt_to_wt", 64'(bus.q_taken), 64'(BHT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
